// File: rtl/hazard_tag_pipe_if.sv
// hazard_tag_pipe_if: groups the tag-pipe input bus, the decode-stage hazard
// query, and the per-stage / hazard outputs of hazard_tag_pipe.
//   master : drives instruction tags, stall/flush and decode query; sees results
//   slave  : the pipe itself
// Per-stage outputs are packed with stage k at [k*W +: W].
interface hazard_tag_pipe_if #(
    parameter int STAGES = 3,
    parameter int AW     = 5,
    parameter int RW     = 3,
    parameter int TW     = 2,
    parameter int SW     = 3
);
    // incoming instruction and pipe control
    logic                 stall_in;
    logic [STAGES-1:0]    flush_vec;
    logic                 valid_i;
    logic [AW-1:0]        ra1_i;
    logic [AW-1:0]        ra2_i;
    logic [AW-1:0]        wa_i;
    logic [RW-1:0]        res_i;
    logic [TW-1:0]        tnew_i;
    // decode-stage hazard query
    logic [AW-1:0]        d_ra1;
    logic [AW-1:0]        d_ra2;
    logic [TW-1:0]        d_tuse1;
    logic [TW-1:0]        d_tuse2;
    // per-stage view
    logic [STAGES-1:0]    valid_o;
    logic [STAGES*AW-1:0] ra1_o;
    logic [STAGES*AW-1:0] ra2_o;
    logic [STAGES*AW-1:0] wa_o;
    logic [STAGES*RW-1:0] res_o;
    logic [STAGES*TW-1:0] tnew_o;
    // hazard result
    logic                 stall_req;
    logic [SW-1:0]        fwd_sel1;
    logic [SW-1:0]        fwd_sel2;

    modport master (
        output stall_in, flush_vec, valid_i, ra1_i, ra2_i, wa_i, res_i, tnew_i,
        output d_ra1, d_ra2, d_tuse1, d_tuse2,
        input  valid_o, ra1_o, ra2_o, wa_o, res_o, tnew_o,
        input  stall_req, fwd_sel1, fwd_sel2
    );

    modport slave (
        input  stall_in, flush_vec, valid_i, ra1_i, ra2_i, wa_i, res_i, tnew_i,
        input  d_ra1, d_ra2, d_tuse1, d_tuse2,
        output valid_o, ra1_o, ra2_o, wa_o, res_o, tnew_o,
        output stall_req, fwd_sel1, fwd_sel2
    );
endinterface

// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe: chain of STAGES tag registers following decode (stage 0 = E).
// Each stage holds valid, ra1, ra2, wa, result type and a Tnew countdown that
// saturates at 0 as the tag moves down. Stage 0 takes a bubble on decode stall
// or invalid input; any stage can be flushed. From the held tags the block
// resolves, for both decode sources, the youngest in-flight writer: it forwards
// from that stage if its result is ready (Tnew==0) and requests a stall if the
// result will not be ready by the time decode needs it (Tnew > Tuse).
// Ports:
//   clk  clock
//   rst  synchronous, active-low reset
//   bus  hazard_tag_pipe_if.slave (tags in, stall/flush, decode query,
//        per-stage tags out, stall_req, fwd_sel1/2)

// One tag stage: register with synchronous clear. A kill or an invalid
// incoming tag stores an all-zero bubble so bubbles can never match.
module hazard_tag_stage #(
    parameter int AW = 5,
    parameter int RW = 3,
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          kill_i,
    input  logic          vld_i,
    input  logic [AW-1:0] ra1_i,
    input  logic [AW-1:0] ra2_i,
    input  logic [AW-1:0] wa_i,
    input  logic [RW-1:0] res_i,
    input  logic [TW-1:0] tnew_i,
    output logic          vld_o,
    output logic [AW-1:0] ra1_o,
    output logic [AW-1:0] ra2_o,
    output logic [AW-1:0] wa_o,
    output logic [RW-1:0] res_o,
    output logic [TW-1:0] tnew_o
);
    logic          vld_q,  vld_d;
    logic [AW-1:0] ra1_q,  ra1_d;
    logic [AW-1:0] ra2_q,  ra2_d;
    logic [AW-1:0] wa_q,   wa_d;
    logic [RW-1:0] res_q,  res_d;
    logic [TW-1:0] tnew_q, tnew_d;

    always_comb begin
        vld_d  = vld_i;
        ra1_d  = ra1_i;
        ra2_d  = ra2_i;
        wa_d   = wa_i;
        res_d  = res_i;
        tnew_d = tnew_i;
        if (kill_i || !vld_i) begin
            vld_d  = 1'b0;
            ra1_d  = '0;
            ra2_d  = '0;
            wa_d   = '0;
            res_d  = '0;
            tnew_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            ra1_q  <= '0;
            ra2_q  <= '0;
            wa_q   <= '0;
            res_q  <= '0;
            tnew_q <= '0;
        end else begin
            vld_q  <= vld_d;
            ra1_q  <= ra1_d;
            ra2_q  <= ra2_d;
            wa_q   <= wa_d;
            res_q  <= res_d;
            tnew_q <= tnew_d;
        end
    end

    assign vld_o  = vld_q;
    assign ra1_o  = ra1_q;
    assign ra2_o  = ra2_q;
    assign wa_o   = wa_q;
    assign res_o  = res_q;
    assign tnew_o = tnew_q;
endmodule

module hazard_tag_pipe #(
    parameter int STAGES = 3,
    parameter int AW     = 5,
    parameter int RW     = 3,
    parameter int TW     = 2,
    parameter int SW     = 3
) (
    input logic            clk,
    input logic            rst,
    hazard_tag_pipe_if.slave bus
);
    // stage register outputs, one element per stage
    logic [STAGES-1:0]         stg_vld;
    logic [STAGES-1:0][AW-1:0] stg_ra1;
    logic [STAGES-1:0][AW-1:0] stg_ra2;
    logic [STAGES-1:0][AW-1:0] stg_wa;
    logic [STAGES-1:0][RW-1:0] stg_res;
    logic [STAGES-1:0][TW-1:0] stg_tnew;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic          kill;
        logic          vin;
        logic [AW-1:0] ra1_in;
        logic [AW-1:0] ra2_in;
        logic [AW-1:0] wa_in;
        logic [RW-1:0] res_in;
        logic [TW-1:0] tnew_in;

        if (k == 0) begin : g_head
            // stall and flush both turn the entry stage into a bubble
            assign kill    = bus.flush_vec[0] | bus.stall_in;
            assign vin     = bus.valid_i;
            assign ra1_in  = bus.ra1_i;
            assign ra2_in  = bus.ra2_i;
            assign wa_in   = bus.wa_i;
            assign res_in  = bus.res_i;
            assign tnew_in = bus.tnew_i;
        end else begin : g_tail
            // downstream stages always advance; Tnew counts down to 0 and stays
            assign kill    = bus.flush_vec[k];
            assign vin     = stg_vld[k-1];
            assign ra1_in  = stg_ra1[k-1];
            assign ra2_in  = stg_ra2[k-1];
            assign wa_in   = stg_wa[k-1];
            assign res_in  = stg_res[k-1];
            assign tnew_in = (stg_tnew[k-1] == '0) ? '0 : stg_tnew[k-1] - TW'(1);
        end

        hazard_tag_stage #(.AW(AW), .RW(RW), .TW(TW)) u_stg (
            .clk    (clk),
            .rst    (rst),
            .kill_i (kill),
            .vld_i  (vin),
            .ra1_i  (ra1_in),
            .ra2_i  (ra2_in),
            .wa_i   (wa_in),
            .res_i  (res_in),
            .tnew_i (tnew_in),
            .vld_o  (stg_vld[k]),
            .ra1_o  (stg_ra1[k]),
            .ra2_o  (stg_ra2[k]),
            .wa_o   (stg_wa[k]),
            .res_o  (stg_res[k]),
            .tnew_o (stg_tnew[k])
        );

        assign bus.valid_o[k]          = stg_vld[k];
        assign bus.ra1_o[k*AW +: AW]   = stg_ra1[k];
        assign bus.ra2_o[k*AW +: AW]   = stg_ra2[k];
        assign bus.wa_o[k*AW +: AW]    = stg_wa[k];
        assign bus.res_o[k*RW +: RW]   = stg_res[k];
        assign bus.tnew_o[k*TW +: TW]  = stg_tnew[k];
    end

    // Hazard resolution, index 0 = source 1, index 1 = source 2.
    logic [1:0][AW-1:0] d_ra;
    logic [1:0][TW-1:0] d_tuse;
    logic [1:0][SW-1:0] sel;
    logic [1:0]         req;
    logic [1:0]         hit;

    assign d_ra   = {bus.d_ra2, bus.d_ra1};
    assign d_tuse = {bus.d_tuse2, bus.d_tuse1};

    // Scan from youngest (stage 0) to oldest; the first hit locks the
    // decision, so older writers of the same register are shadowed.
    always_comb begin
        sel = '0;
        req = '0;
        hit = '0;
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < STAGES; k++) begin
                if (!hit[j] && stg_vld[k] && (stg_wa[k] != '0) &&
                    (stg_wa[k] == d_ra[j])) begin
                    hit[j] = 1'b1;
                    if (stg_tnew[k] == '0)
                        sel[j] = SW'(k + 1);
                    req[j] = (stg_tnew[k] > d_tuse[j]);
                end
            end
        end
    end

    assign bus.stall_req = |req;
    assign bus.fwd_sel1  = sel[0];
    assign bus.fwd_sel2  = sel[1];
endmodule

// File: tb/tb_hazard_tag_pipe.sv
module tb_hazard_tag_pipe;
    localparam int STAGES = 3;
    localparam int AW = 5;
    localparam int RW = 3;
    localparam int TW = 2;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_tag_pipe_if #(.STAGES(STAGES), .AW(AW), .RW(RW), .TW(TW), .SW(SW)) bus ();

    hazard_tag_pipe #(.STAGES(STAGES), .AW(AW), .RW(RW), .TW(TW), .SW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model: one record per stage, youngest at index 0
    int m_vld [STAGES];
    int m_ra1 [STAGES];
    int m_ra2 [STAGES];
    int m_wa  [STAGES];
    int m_res [STAGES];
    int m_tn  [STAGES];

    // apply one clock edge to both DUT and model
    task automatic tick();
        int nv[STAGES], n1[STAGES], n2[STAGES], nw[STAGES], nr[STAGES], nt[STAGES];
        for (int k = 0; k < STAGES; k++) begin
            nv[k] = 0; n1[k] = 0; n2[k] = 0; nw[k] = 0; nr[k] = 0; nt[k] = 0;
        end
        if (rst) begin
            for (int k = 1; k < STAGES; k++) begin
                if (!bus.flush_vec[k] && m_vld[k-1] != 0) begin
                    nv[k] = 1; n1[k] = m_ra1[k-1]; n2[k] = m_ra2[k-1];
                    nw[k] = m_wa[k-1]; nr[k] = m_res[k-1];
                    nt[k] = (m_tn[k-1] > 0) ? m_tn[k-1] - 1 : 0;
                end
            end
            if (!bus.flush_vec[0] && !bus.stall_in && bus.valid_i) begin
                nv[0] = 1; n1[0] = int'(bus.ra1_i); n2[0] = int'(bus.ra2_i);
                nw[0] = int'(bus.wa_i); nr[0] = int'(bus.res_i); nt[0] = int'(bus.tnew_i);
            end
        end
        @(posedge clk);
        for (int k = 0; k < STAGES; k++) begin
            m_vld[k] = nv[k]; m_ra1[k] = n1[k]; m_ra2[k] = n2[k];
            m_wa[k] = nw[k]; m_res[k] = nr[k]; m_tn[k] = nt[k];
        end
        #1;
    endtask

    // youngest valid nonzero writer of ra decides forwarding and stall
    function automatic void model_haz(input int ra, input int tuse, output int sel, output int st);
        sel = 0; st = 0;
        for (int k = 0; k < STAGES; k++) begin
            if (m_vld[k] != 0 && m_wa[k] != 0 && m_wa[k] == ra) begin
                sel = (m_tn[k] == 0) ? k + 1 : 0;
                st  = (m_tn[k] > tuse) ? 1 : 0;
                break;
            end
        end
    endfunction

    task automatic set_in(input int v, input int r1, input int r2, input int w, input int rs, input int tn);
        bus.valid_i = v[0];
        bus.ra1_i = AW'(r1); bus.ra2_i = AW'(r2); bus.wa_i = AW'(w);
        bus.res_i = RW'(rs); bus.tnew_i = TW'(tn);
    endtask

    task automatic set_dec(input int r1, input int r2, input int t1, input int t2);
        bus.d_ra1 = AW'(r1); bus.d_ra2 = AW'(r2);
        bus.d_tuse1 = TW'(t1); bus.d_tuse2 = TW'(t2);
        #1;
    endtask

    task automatic drain();
        bus.stall_in = 1'b0; bus.flush_vec = '0;
        set_in(0, 0, 0, 0, 0, 0);
        repeat (STAGES) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.stall_in = 1'b0; bus.flush_vec = '0;
        set_in(1, $urandom_range(1, 31), $urandom_range(1, 31), $urandom_range(1, 31),
               $urandom_range(0, 7), $urandom_range(0, 3));
        set_dec(int'(bus.wa_i), int'(bus.wa_i), 0, 0);
        tick(); tick();
        checks++; if (bus.valid_o !== 3'b000) begin errors++; $display("FAIL reset_valid got %b exp 000", bus.valid_o); end
        checks++; if (bus.wa_o !== '0 || bus.ra1_o !== '0 || bus.ra2_o !== '0) begin errors++; $display("FAIL reset_addr got wa=%h ra1=%h ra2=%h exp 0", bus.wa_o, bus.ra1_o, bus.ra2_o); end
        checks++; if (bus.res_o !== '0 || bus.tnew_o !== '0) begin errors++; $display("FAIL reset_res_tnew got %h %h exp 0", bus.res_o, bus.tnew_o); end
        checks++; if (bus.stall_req !== 1'b0 || bus.fwd_sel1 !== 3'd0 || bus.fwd_sel2 !== 3'd0) begin errors++; $display("FAIL reset_haz got st=%b s1=%0d s2=%0d exp 0", bus.stall_req, bus.fwd_sel1, bus.fwd_sel2); end
        rst = 1'b1;
    endtask

    task automatic test_propagation();
        drain();
        set_in(1, 1, 2, 5, 2, 2); tick();
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (bus.valid_o !== 3'b001 || bus.wa_o[4:0] !== 5'd5 || bus.tnew_o[1:0] !== 2'd2 || bus.res_o[2:0] !== 3'd2)
            begin errors++; $display("FAIL prop_s0 got v=%b wa=%0d tn=%0d res=%0d exp 001 5 2 2", bus.valid_o, bus.wa_o[4:0], bus.tnew_o[1:0], bus.res_o[2:0]); end
        tick();
        checks++; if (bus.valid_o !== 3'b010 || bus.wa_o[9:5] !== 5'd5 || bus.tnew_o[3:2] !== 2'd1)
            begin errors++; $display("FAIL prop_s1 got v=%b wa=%0d tn=%0d exp 010 5 1", bus.valid_o, bus.wa_o[9:5], bus.tnew_o[3:2]); end
        tick();
        checks++; if (bus.valid_o !== 3'b100 || bus.wa_o[14:10] !== 5'd5 || bus.tnew_o[5:4] !== 2'd0 || bus.res_o[8:6] !== 3'd2)
            begin errors++; $display("FAIL prop_s2 got v=%b wa=%0d tn=%0d res=%0d exp 100 5 0 2", bus.valid_o, bus.wa_o[14:10], bus.tnew_o[5:4], bus.res_o[8:6]); end
        // saturation: tnew=1 hits 0 at stage 1 and stays 0 at stage 2
        set_in(1, 0, 0, 6, 1, 1); tick();
        set_in(0, 0, 0, 0, 0, 0); tick(); tick();
        checks++; if (bus.tnew_o[5:4] !== 2'd0 || bus.wa_o[14:10] !== 5'd6)
            begin errors++; $display("FAIL prop_sat got tn=%0d wa=%0d exp 0 6", bus.tnew_o[5:4], bus.wa_o[14:10]); end
    endtask

    task automatic test_stall_bubble();
        drain();
        set_in(1, 1, 1, 6, 3, 3); tick();
        bus.stall_in = 1'b1; set_in(1, 2, 2, 7, 1, 1); tick();
        bus.stall_in = 1'b0; set_in(0, 0, 0, 0, 0, 0);
        checks++; if (bus.valid_o[0] !== 1'b0 || bus.wa_o[4:0] !== 5'd0)
            begin errors++; $display("FAIL stall_bubble got v0=%b wa0=%0d exp 0 0", bus.valid_o[0], bus.wa_o[4:0]); end
        checks++; if (bus.valid_o[1] !== 1'b1 || bus.wa_o[9:5] !== 5'd6 || bus.tnew_o[3:2] !== 2'd2 || bus.res_o[5:3] !== 3'd3)
            begin errors++; $display("FAIL stall_adv got v1=%b wa1=%0d tn1=%0d res1=%0d exp 1 6 2 3", bus.valid_o[1], bus.wa_o[9:5], bus.tnew_o[3:2], bus.res_o[5:3]); end
    endtask

    task automatic test_forward_priority();
        drain();
        set_in(1, 0, 0, 3, 1, 0); tick();   // older writer of r3
        set_in(1, 0, 0, 0, 1, 3); tick();   // valid, writes r0, long latency
        set_in(1, 0, 0, 3, 2, 0); tick();   // youngest writer of r3
        set_in(0, 0, 0, 0, 0, 0);
        set_dec(3, 0, 0, 0);
        checks++; if (bus.fwd_sel1 !== 3'd1) begin errors++; $display("FAIL fwd_youngest got %0d exp 1", bus.fwd_sel1); end
        checks++; if (bus.fwd_sel2 !== 3'd0 || bus.stall_req !== 1'b0)
            begin errors++; $display("FAIL fwd_r0 got s2=%0d st=%b exp 0 0", bus.fwd_sel2, bus.stall_req); end
        set_dec(3, 3, 0, 0);
        checks++; if (bus.fwd_sel1 !== 3'd1 || bus.fwd_sel2 !== 3'd1)
            begin errors++; $display("FAIL fwd_both got s1=%0d s2=%0d exp 1 1", bus.fwd_sel1, bus.fwd_sel2); end
        tick();  // r3 writers now at stages 1 and 3(gone): stage1 tnew 0, stage2 r0
        checks++; if (bus.fwd_sel1 !== 3'd2) begin errors++; $display("FAIL fwd_stage1 got %0d exp 2", bus.fwd_sel1); end
    endtask

    task automatic test_stall_request();
        drain();
        set_in(1, 0, 0, 4, 1, 2); tick();
        set_in(0, 0, 0, 0, 0, 0);
        set_dec(4, 0, 1, 0);
        checks++; if (bus.stall_req !== 1'b1 || bus.fwd_sel1 !== 3'd0)
            begin errors++; $display("FAIL streq_stall got st=%b s1=%0d exp 1 0", bus.stall_req, bus.fwd_sel1); end
        set_dec(4, 0, 2, 0);
        checks++; if (bus.stall_req !== 1'b0 || bus.fwd_sel1 !== 3'd0)
            begin errors++; $display("FAIL streq_tuse got st=%b s1=%0d exp 0 0", bus.stall_req, bus.fwd_sel1); end
        drain();
        set_in(1, 0, 0, 4, 1, 1); tick();
        set_in(1, 0, 0, 4, 1, 2); tick();
        set_in(0, 0, 0, 0, 0, 0);
        set_dec(0, 4, 0, 1);
        checks++; if (bus.fwd_sel2 !== 3'd0 || bus.stall_req !== 1'b1)
            begin errors++; $display("FAIL streq_youngest got s2=%0d st=%b exp 0 1", bus.fwd_sel2, bus.stall_req); end
    endtask

    task automatic test_flush();
        drain();
        set_in(1, 1, 2, 9, 4, 1); tick();
        bus.flush_vec = 3'b010; set_in(1, 3, 4, 10, 5, 2); tick();
        checks++; if (bus.valid_o[1] !== 1'b0 || bus.wa_o[9:5] !== 5'd0 || bus.wa_o[4:0] !== 5'd10)
            begin errors++; $display("FAIL flush_s1 got v1=%b wa1=%0d wa0=%0d exp 0 0 10", bus.valid_o[1], bus.wa_o[9:5], bus.wa_o[4:0]); end
        bus.flush_vec = 3'b001; bus.stall_in = 1'b1; set_in(1, 5, 6, 11, 6, 3); tick();
        bus.flush_vec = '0; bus.stall_in = 1'b0; set_in(0, 0, 0, 0, 0, 0);
        checks++; if (bus.valid_o !== 3'b010 || bus.wa_o[4:0] !== 5'd0 || bus.wa_o[9:5] !== 5'd10 || bus.tnew_o[3:2] !== 2'd1)
            begin errors++; $display("FAIL flush_stall got v=%b wa0=%0d wa1=%0d tn1=%0d exp 010 0 10 1", bus.valid_o, bus.wa_o[4:0], bus.wa_o[9:5], bus.tnew_o[3:2]); end
        // reset mid-stream, then the very next edge loads again
        set_in(1, 1, 1, 12, 1, 1); tick();
        rst = 1'b0; tick();
        checks++; if (bus.valid_o !== 3'b000 || bus.wa_o !== '0)
            begin errors++; $display("FAIL midreset got v=%b wa=%h exp 000 0", bus.valid_o, bus.wa_o); end
        rst = 1'b1; tick();
        checks++; if (bus.valid_o !== 3'b001 || bus.wa_o[4:0] !== 5'd12)
            begin errors++; $display("FAIL reset_release got v=%b wa0=%0d exp 001 12", bus.valid_o, bus.wa_o[4:0]); end
    endtask

    task automatic test_random();
        logic [STAGES-1:0]    ev;
        logic [STAGES*AW-1:0] e1, e2, ew;
        logic [STAGES*RW-1:0] er;
        logic [STAGES*TW-1:0] et;
        int s1, s2, q1, q2;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) != 0);
            bus.stall_in = ($urandom_range(0, 3) == 0);
            bus.flush_vec = ($urandom_range(0, 4) == 0) ? STAGES'($urandom) : '0;
            set_in(($urandom_range(0, 4) != 0) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
            tick();
            set_dec($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3));
            for (int k = 0; k < STAGES; k++) begin
                ev[k] = m_vld[k][0];
                e1[k*AW +: AW] = AW'(m_ra1[k]); e2[k*AW +: AW] = AW'(m_ra2[k]);
                ew[k*AW +: AW] = AW'(m_wa[k]);  er[k*RW +: RW] = RW'(m_res[k]);
                et[k*TW +: TW] = TW'(m_tn[k]);
            end
            model_haz(int'(bus.d_ra1), int'(bus.d_tuse1), s1, q1);
            model_haz(int'(bus.d_ra2), int'(bus.d_tuse2), s2, q2);
            checks++; if (bus.valid_o !== ev || bus.wa_o !== ew || bus.tnew_o !== et)
                begin errors++; $display("FAIL rnd_tags cyc %0d got v=%b wa=%h tn=%h exp v=%b wa=%h tn=%h", i, bus.valid_o, bus.wa_o, bus.tnew_o, ev, ew, et); end
            checks++; if (bus.ra1_o !== e1 || bus.ra2_o !== e2 || bus.res_o !== er)
                begin errors++; $display("FAIL rnd_src cyc %0d got %h %h %h exp %h %h %h", i, bus.ra1_o, bus.ra2_o, bus.res_o, e1, e2, er); end
            checks++; if (bus.fwd_sel1 !== SW'(s1) || bus.fwd_sel2 !== SW'(s2) || bus.stall_req !== ((q1 | q2) != 0))
                begin errors++; $display("FAIL rnd_haz cyc %0d got s1=%0d s2=%0d st=%b exp %0d %0d %0d", i, bus.fwd_sel1, bus.fwd_sel2, bus.stall_req, s1, s2, q1 | q2); end
        end
        rst = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < STAGES; k++) begin
            m_vld[k] = 0; m_ra1[k] = 0; m_ra2[k] = 0; m_wa[k] = 0; m_res[k] = 0; m_tn[k] = 0;
        end
        bus.stall_in = 1'b0; bus.flush_vec = '0;
        set_in(0, 0, 0, 0, 0, 0);
        set_dec(0, 0, 0, 0);
        test_reset();
        test_propagation();
        test_stall_bubble();
        test_forward_priority();
        test_stall_request();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_tag_pipe.md
Name: hazard_tag_pipe

Overview:
- Parametrised hazard-tag pipeline register chain for the multi-cycle CPU.
- Carries register-read and write tags plus a result-type code and a Tnew countdown from the E stage through STAGES downstream stages.
- Per-stage flush and bubble insertion on decode stall.
- From the held tags, computes the stall request and forwarding selects for the two decode-stage source operands.

Parameters:
- STAGES, 3, number of tag stages after decode (stage 0 = E, 1 = M, 2 = W); 1..7.
- AW, 5, register address width.
- RW, 3, result-type code width.
- TW, 2, Tnew/Tuse counter width.
- SW, 3, forward-select width; must satisfy 2^SW > STAGES.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- stall_in  in  1  decode stall; stage 0 loads a bubble this edge.
- flush_vec  in  STAGES  per-stage synchronous clear; bit k clears stage k.
- valid_i  in  1  incoming instruction valid.
- ra1_i  in  AW  source register 1 address.
- ra2_i  in  AW  source register 2 address.
- wa_i  in  AW  destination register address.
- res_i  in  RW  result-type code.
- tnew_i  in  TW  cycles until the result exists, at stage 0 entry.
- d_ra1  in  AW  decode-stage source 1 address.
- d_ra2  in  AW  decode-stage source 2 address.
- d_tuse1  in  TW  cycles until decode needs source 1.
- d_tuse2  in  TW  cycles until decode needs source 2.
- valid_o  out  STAGES  per-stage valid.
- ra1_o  out  STAGES*AW  per-stage ra1; stage k at bits [k*AW +: AW].
- ra2_o  out  STAGES*AW  per-stage ra2, same packing.
- wa_o  out  STAGES*AW  per-stage wa, same packing.
- res_o  out  STAGES*RW  per-stage result type.
- tnew_o  out  STAGES*TW  per-stage Tnew.
- stall_req  out  1  decode must stall (combinational).
- fwd_sel1  out  SW  source 1 forward select: 0 = register file, k = stage k-1.
- fwd_sel2  out  SW  source 2 forward select, same encoding.

Behaviour:

Reset and register update (all on posedge clk):
- Priority per stage: rst low > flush_vec[k] > normal load.
- rst low: every stage field and valid cleared to 0. All outputs are then 0, including stall_req and fwd_sel.
- flush_vec[k]=1: stage k becomes a bubble (all fields 0, valid 0). Other stages update normally. Flush beats stall.

Stage 0 load:
- stall_in=1: stage 0 loads a bubble.
- Otherwise stage 0 loads ra1_i, ra2_i, wa_i, res_i, tnew_i, valid_i.
- If valid_i=0, stage 0 stores a bubble regardless of the other inputs.

Stage advance:
- Stage k (k>=1) loads stage k-1 every cycle. There is no hold; stall only affects stage 0.
- On advance, tnew saturates down: next = (prev==0) ? 0 : prev-1.

Latency:
- A tag presented at an edge appears on stage 0 outputs after that edge.
- It reaches stage k after k+1 edges.

Hazard logic (combinational from stage registers and d_* inputs):
- A stage "matches" source j when valid=1, wa!=0, and wa==d_raj.
- Register 0 never matches.
- For each source, take the youngest (lowest index) matching stage m.
- Older matches are ignored, because the youngest write is the architecturally current one.
- If m exists and tnew_m==0: fwd_selj = m+1.
- Otherwise fwd_selj = 0.
- If m exists and tnew_m > d_tusej: source j requests a stall.
- stall_req = OR of both source requests.
- Both sources may select the same stage.

Boundary cases:
- Bubble stages never match.
- Simultaneous stall_in and flush_vec[0]: stage 0 becomes a bubble; both give the same result.
- Reset asserted mid-stream clears all stages on the next edge. Deasserting reset lets stage 0 load on the following edge.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with valid_i=1 and random tags -> all outputs 0, stall_req=0, fwd_sel1=fwd_sel2=0.
2. Propagation: load wa=5, res=2, tnew=2 at cycle 0 -> stage 0 shows tnew=2, stage 1 shows tnew=1, stage 2 shows tnew=0, then stays 0 (saturation).
3. Stall/bubble:
   - With stall_in=1 while valid_i=1, wa=7 -> stage 0 is a bubble with valid_o[0]=0.
   - The instruction previously in stage 0 advances to stage 1 unchanged apart from the tnew decrement.
4. Forward priority:
   - Setup: stage 0 wa=3 tnew=0; stage 2 wa=3 tnew=0; d_ra1=3 -> fwd_sel1=1.
   - Set d_ra2=0 with stage wa=0 -> fwd_sel2=0 and no stall.
5. Stall request:
   - Stage 0 wa=4 tnew=2; d_ra1=4, d_tuse1=1 -> stall_req=1, fwd_sel1=0.
   - Change d_tuse1 to 2 -> stall_req=0.
   - Youngest-only check: with an older stage 1 wa=4 tnew=0 also present, fwd_sel1 stays 0.
6. Flush: flush_vec=3'b010 while stage 0 holds wa=9 -> next cycle stage 1 is a bubble and stage 0 holds the new input. With flush_vec=3'b001 and stall_in=1 together -> stage 0 is a bubble.
